// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port GPR file for the ID stage.
// NRD combinational read ports with same-cycle write bypass, NWR write
// ports (higher index = younger, wins on address collision), register 0
// hardwired to zero, and a per-register busy scoreboard with a registered
// popcount for the hazard logic.
module regfile_mp #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 3,
  parameter int NWR = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] waddr,
  input  logic [NWR*DW-1:0] wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_dst,
  input  logic              flush,
  output logic [AW:0]       busy_cnt
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busyNext;
  logic [CW-1:0]    cntNext;

  // Register array update; ports are walked in ascending order so the
  // youngest (highest-index) writer to an address lands last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs[k] <= '0;
      end
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && (waddr[i*AW +: AW] != '0)) begin
          regs[waddr[i*AW +: AW]] <= wdata[i*DW +: DW];
        end
      end
    end
  end

  // Read ports: array value, overridden by the youngest same-cycle write
  // to that address; a forwarded writeback also hides the busy bit.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int j = 0; j < NRD; j++) begin
      rdata[j*DW +: DW] = regs[raddr[j*AW +: AW]];
      rbusy[j]          = busy[raddr[j*AW +: AW]];
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && (waddr[i*AW +: AW] == raddr[j*AW +: AW])) begin
          rdata[j*DW +: DW] = wdata[i*DW +: DW];
          rbusy[j]          = 1'b0;
        end
      end
      if (rst || (raddr[j*AW +: AW] == '0)) begin
        rdata[j*DW +: DW] = '0;
        rbusy[j]          = 1'b0;
      end
    end
  end

  // Next scoreboard state: flush clears everything and drops the issue;
  // otherwise writebacks clear and a new issue sets, set taking priority.
  always_comb begin
    busyNext = busy;
    if (flush) begin
      busyNext = '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (we[i]) begin
          busyNext[waddr[i*AW +: AW]] = 1'b0;
        end
      end
      if (iss_valid) begin
        busyNext[iss_dst] = 1'b1;
      end
    end
    busyNext[0] = 1'b0;
  end

  // Population count of the next scoreboard, so busy_cnt tracks busy.
  always_comb begin
    cntNext = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cntNext = cntNext + CW'(busyNext[k]);
    end
  end

  // Scoreboard and its count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busyNext;
      busy_cnt <= cntNext;
    end
  end

endmodule
